// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet parser stages.
//   ethertype_t          : 16-bit resolved EtherType
//   ETHERTYPE_*          : well-known EtherType values
//   PROTO_CLASS_*        : class codes used by the protocol classifier
//   proto_match_entry_t  : one match-table entry {en, ethertype, cls}
//   proto_default_entry  : power-on contents of a match-table slot
package eth_parser_pkg;

    typedef logic [15:0] ethertype_t;

    localparam ethertype_t ETHERTYPE_IPV4 = 16'h0800;
    localparam ethertype_t ETHERTYPE_IPV6 = 16'h86DD;
    localparam ethertype_t ETHERTYPE_ARP  = 16'h0806;

    localparam int PROTO_CLASS_UNKNOWN = 0;
    localparam int PROTO_CLASS_IPV4    = 1;
    localparam int PROTO_CLASS_IPV6    = 2;
    localparam int PROTO_CLASS_ARP     = 3;

    // Stored class field is sized for the widest classifier we expect;
    // users keep only their low CLASS_W bits.
    localparam int PROTO_CLS_W = 8;

    typedef struct packed {
        logic                   en;
        ethertype_t             ethertype;
        logic [PROTO_CLS_W-1:0] cls;
    } proto_match_entry_t;

    function automatic proto_match_entry_t proto_default_entry(input int idx);
        proto_match_entry_t e;
        e = '0;
        case (idx)
            0: e = '{en: 1'b1, ethertype: ETHERTYPE_IPV4, cls: PROTO_CLS_W'(PROTO_CLASS_IPV4)};
            1: e = '{en: 1'b1, ethertype: ETHERTYPE_IPV6, cls: PROTO_CLS_W'(PROTO_CLASS_IPV6)};
            2: e = '{en: 1'b1, ethertype: ETHERTYPE_ARP,  cls: PROTO_CLS_W'(PROTO_CLASS_ARP)};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/eth_stat_counter_bank.sv
// Bank of 2**IDX_W saturating statistics counters.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of every counter (wins over inc_en)
//   inc_en     : increment counter inc_idx this edge
//   inc_idx    : counter to increment
//   rd_idx     : counter to read
//   rd_data    : combinational read of the selected counter
module eth_stat_counter_bank #(
    parameter int IDX_W   = 3,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc_en,
    input  logic [IDX_W-1:0]   inc_idx,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [COUNT_W-1:0] rd_data
);

    localparam int NUM_CNT = 2 ** IDX_W;

    logic [COUNT_W-1:0] cnt [NUM_CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
        end else if (inc_en && (cnt[inc_idx] != '1)) begin
            cnt[inc_idx] <= cnt[inc_idx] + COUNT_W'(1);
        end
    end

    assign rd_data = cnt[rd_idx];

endmodule

// File: rtl/eth_proto_classify_tbl.sv
// Programmable EtherType classifier with a run-time writable match table.
//   in_*   : one resolved EtherType per valid/ready beat, plus hdr_ok and tag
//   out_*  : registered result (1-cycle latency), held while stalled
//   cfg_*  : table write port; takes effect on the edge, so a beat in the
//            same cycle still sees the old contents
//   stat_* : per-class saturating hit counters, bad-header counter, clear
// NUM_ENTRIES must be >= 3 (reset defaults occupy entries 0..2);
// CLASS_W must not exceed PROTO_CLS_W.
module eth_proto_classify_tbl
    import eth_parser_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int CLASS_W     = 3,
    parameter int COUNT_W     = 32,
    parameter int ID_W        = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  ethertype_t                     in_ethertype,
    input  logic                           in_hdr_ok,
    input  logic [ID_W-1:0]                in_id,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CLASS_W-1:0]             out_class,
    output logic                           out_hit,
    output logic                           out_hdr_ok,
    output logic [ID_W-1:0]                out_id,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_idx,
    input  logic                           cfg_en,
    input  ethertype_t                     cfg_ethertype,
    input  logic [CLASS_W-1:0]             cfg_class,
    input  logic [CLASS_W-1:0]             stat_sel,
    output logic [COUNT_W-1:0]             stat_count,
    output logic [COUNT_W-1:0]             stat_bad,
    input  logic                           stat_clr
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    proto_match_entry_t tbl [NUM_ENTRIES];

    logic               xfer;
    logic [CLASS_W-1:0] lkp_cls;
    logic               lkp_hit;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    // Scan from the top down so the lowest matching index is the last
    // assignment and therefore wins. A class-0 entry still reports a hit.
    always_comb begin
        lkp_cls = '0;
        lkp_hit = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (tbl[i].en && (tbl[i].ethertype == in_ethertype)) begin
                lkp_hit = 1'b1;
                lkp_cls = CLASS_W'(tbl[i].cls);
            end
        end
        if (!in_hdr_ok) begin
            lkp_cls = '0;
            lkp_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) tbl[i] <= proto_default_entry(i);
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    tbl[i] <= '{en: cfg_en, ethertype: cfg_ethertype,
                               cls: PROTO_CLS_W'(cfg_class)};
                end
            end
        end
    end

    // Output register: loads only on a transfer, so a stalled result is
    // untouched by table writes or new input beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_class  <= '0;
            out_hit    <= 1'b0;
            out_hdr_ok <= 1'b0;
            out_id     <= '0;
        end else begin
            if (in_ready) out_valid <= in_valid;
            if (xfer) begin
                out_class  <= lkp_cls;
                out_hit    <= lkp_hit;
                out_hdr_ok <= in_hdr_ok;
                out_id     <= in_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bad <= '0;
        end else if (stat_clr) begin
            stat_bad <= '0;
        end else if (xfer && !in_hdr_ok && (stat_bad != '1)) begin
            stat_bad <= stat_bad + COUNT_W'(1);
        end
    end

    eth_stat_counter_bank #(
        .IDX_W   (CLASS_W),
        .COUNT_W (COUNT_W)
    ) u_cls_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (stat_clr),
        .inc_en  (xfer && in_hdr_ok),
        .inc_idx (lkp_cls),
        .rd_idx  (stat_sel),
        .rd_data (stat_count)
    );

endmodule

// File: doc/eth_proto_classify_tbl.md
Name: eth_proto_classify_tbl

Overview:
- Programmable, pipelined successor to the fixed IPv4/IPv6/ARP payload classifier.
- Accepts one resolved EtherType per handshake and looks it up in a run-time-writable match table.
- Emits a registered class code with valid/ready back-pressure and keeps saturating per-class hit counters.
- Sits between the VLAN/EtherType resolver and the L3 dispatch stage.

Parameters:
- NUM_ENTRIES, 8, match-table depth; must be ≥3.
- CLASS_W, 3, class-code width. NUM_CLASSES = 2**CLASS_W. Class 0 is reserved for "unknown".
- COUNT_W, 32, per-class statistics counter width.
- ID_W, 8, width of the opaque frame tag carried alongside.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted.
- in_ethertype  in  16 (ethertype_t)  resolved EtherType.
- in_hdr_ok  in  1  header/VLAN parse succeeded.
- in_id  in  ID_W  frame tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_class  out  CLASS_W  matched class; 0 = unknown or bad header.
- out_hit  out  1  a table entry matched.
- out_hdr_ok  out  1  registered copy of in_hdr_ok.
- out_id  out  ID_W  registered copy of in_id.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  $clog2(NUM_ENTRIES)  entry index.
- cfg_en  in  1  entry enable.
- cfg_ethertype  in  16  entry match value.
- cfg_class  in  CLASS_W  entry class code.
- stat_sel  in  CLASS_W  counter select.
- stat_count  out  COUNT_W  selected class counter.
- stat_bad  out  COUNT_W  count of beats with in_hdr_ok=0.
- stat_clr  in  1  synchronous clear of all counters.

Behaviour:
- Reset (rst_n low, async) outputs: out_valid=0; out_class=0; out_hit=0; out_hdr_ok=0; out_id=0; all counters=0.
- Reset table contents:
  - entry0 = {en=1, 0x0800, class 1}.
  - entry1 = {en=1, 0x86DD, class 2}.
  - entry2 = {en=1, 0x0806, class 3}.
  - all other entries disabled, value 0, class 0.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Transfer occurs when in_valid && in_ready.
  - Latency is exactly 1 cycle: the result is registered and out_valid rises on the following edge.
  - out_* holds stable while out_valid && !out_ready.
  - Back-to-back transfers sustain 1 beat per cycle.
- Lookup (combinational on input, registered on output):
  - If in_hdr_ok=0: out_class=0, out_hit=0.
  - Otherwise scan all enabled entries; the lowest index whose value equals in_ethertype wins.
  - On a match: out_class = entry class, out_hit=1. On no match: out_class=0, out_hit=0.
  - An enabled entry with class 0 matches and sets out_hit=1 while reporting class 0. This is an explicit "known-drop" rule.
- Table write:
  - cfg_we applies on the clock edge; the new contents are visible to lookups from the next cycle onward.
  - When a write and a transfer occur in the same cycle, the lookup uses the pre-write contents.
  - A write is permitted while a result is stalled; the stalled result does not change.
- Counters:
  - Increment once per input transfer, never on output stall cycles.
  - in_hdr_ok=1 beats increment the counter of the resulting out_class (including class 0 when unknown).
  - in_hdr_ok=0 beats increment stat_bad only.
  - All counters saturate at all-ones; no wrap.
  - stat_clr zeroes every counter on the edge. If a transfer occurs in the same cycle, clear wins and that beat is not counted.
  - stat_count = counter[stat_sel]; this is a combinational read of registered state.
- Reset mid-operation: an in-flight result is discarded; the table returns to its defaults.

Decomposition:
- Add to eth_parser_pkg:
  - ethertype_t and the ETHERTYPE_IPV4/IPV6/ARP constants (already present).
  - New localparams PROTO_CLASS_UNKNOWN=0, PROTO_CLASS_IPV4=1, PROTO_CLASS_IPV6=2, PROTO_CLASS_ARP=3.
  - Packed struct proto_match_entry_t {en, ethertype, cls}.
- Sub-module: eth_stat_counter_bank. Holds NUM_CLASSES saturating counters with inc_en, inc_idx and clr inputs, and a read mux. It is reused later by other parser stages.

Test Plan:
1. Reset then send 0x0800, 0x86DD, 0x0806, 0x88CC with hdr_ok=1 and out_ready=1 → classes 1, 2, 3, 0 one cycle after each beat. out_hit = 1, 1, 1, 0. stat_count for classes 0..3 = 1 each.
2. Send a beat with hdr_ok=0 and ethertype 0x0800 → out_class=0, out_hit=0, out_hdr_ok=0. stat_bad=1; class-1 counter unchanged.
3. Hold out_ready=0 for 4 cycles with in_valid=1 → one beat accepted, in_ready=0 for the remaining stalled cycles, out_* stable. Release → next beat follows in the next cycle; counters +2 total, not +5.
4. Write entry3={1, 0x88F7, class 5} in the same cycle a 0x88F7 beat transfers → that beat yields class 0. An identical beat on the next cycle yields class 5.
5. Write entry1={1, 0x0800, class 6} → 0x0800 still maps to class 1 (entry0 has priority). Disable entry0 → 0x0800 maps to class 6.
6. With COUNT_W=4, send 17 IPv4 beats → class-1 counter reads 15 (saturated). Assert stat_clr together with an 18th beat → all counters read 0 afterwards.
